// File: rtl/dmem_pkg.sv
// dmem_pkg
// Shared types and constants for the data-memory arbiter slice:
//   state_t    - read-return FSM states used by dmem_arbiter
//   owner_t    - which requester currently owns the memory port
//   ALIGN_MASK - low address bits that must be zero for a word access
//   is_aligned - helper applying ALIGN_MASK to the low address bits
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD_A = 2'd1,
        ST_RD_B = 2'd2
    } state_t;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. Grant is combinational from the requests and
// the last-grant pointer; the pointer only moves when a grant is issued.
// Ports:
//   clock - rising-edge clock
//   reset - synchronous active-high reset; forces gnt low, pointer to "B last"
//   req   - [0] requester A, [1] requester B
//   gnt   - one-hot grant, same bit order as req
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    owner_t last_own;

    always_comb begin
        gnt = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Tie: whoever was not served last goes first.
                2'b11:   gnt = (last_own == OWN_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_own <= OWN_B;
        end else if (gnt[0]) begin
            last_own <= OWN_A;
        end else if (gnt[1]) begin
            last_own <= OWN_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one synchronous-read memory port between a CPU (A) and a DMA (B).
// One transaction per cycle; reads return exactly one cycle after grant.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | no read data due this cycle
//   ST_RD_A | mem_dataout carries the read granted to A last cycle
//   ST_RD_B | mem_dataout carries the read granted to B last cycle
//
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   a_*/b_* req,we,addr,wdata - requester command, held until gnt
//   a_gnt/b_gnt             - request accepted this cycle (combinational)
//   a_rvalid/a_rdata, b_*   - read return, rdata zero when not valid
//   err                     - pulses in the grant cycle of a misaligned access
//   mem_addr/mem_datain/mem_we/mem_io_sel - memory-side command
//   mem_dataout             - memory read data, one cycle after address
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int IO_BIT = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          a_gnt,
    output logic          b_gnt,
    output logic          a_rvalid,
    output logic          b_rvalid,
    output logic [DW-1:0] a_rdata,
    output logic [DW-1:0] b_rdata,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_datain,
    output logic          mem_we,
    output logic          mem_io_sel,
    input  logic [DW-1:0] mem_dataout
);

    logic [1:0]    gnt;
    logic          granted;
    owner_t        own;
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          aligned;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    state_t        state;

    rr_arb2 u_rr_arb2 (
        .clock (clock),
        .reset (reset),
        .req   ({b_req, a_req}),
        .gnt   (gnt)
    );

    assign a_gnt   = gnt[0];
    assign b_gnt   = gnt[1];
    assign granted = gnt[0] | gnt[1];
    assign own     = gnt[1] ? OWN_B : OWN_A;

    always_comb begin
        own_we    = a_we;
        own_addr  = a_addr;
        own_wdata = a_wdata;
        if (own == OWN_B) begin
            own_we    = b_we;
            own_addr  = b_addr;
            own_wdata = b_wdata;
        end
    end

    assign aligned = is_aligned(own_addr[1:0]);

    // Address/data follow the owner while granted and otherwise hold the
    // last granted values so the memory sees a quiet bus between accesses.
    always_comb begin
        mem_addr   = addr_q;
        mem_datain = wdata_q;
        if (reset) begin
            mem_addr   = '0;
            mem_datain = '0;
        end else if (granted) begin
            mem_addr   = own_addr;
            mem_datain = own_wdata;
        end
    end

    assign mem_io_sel = mem_addr[IO_BIT];
    assign mem_we     = granted & own_we & aligned;
    assign err        = granted & ~aligned;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            if (granted) begin
                addr_q  <= own_addr;
                wdata_q <= own_wdata;
            end
            if (granted && !own_we && aligned) begin
                state <= (own == OWN_A) ? ST_RD_A : ST_RD_B;
            end else begin
                state <= ST_IDLE;
            end
        end
    end

    // Gating with reset drops a read return that would land in a reset cycle.
    assign a_rvalid = ~reset & (state == ST_RD_A);
    assign b_rvalid = ~reset & (state == ST_RD_B);
    assign a_rdata  = a_rvalid ? mem_dataout : '0;
    assign b_rdata  = b_rvalid ? mem_dataout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model of the arbiter and memory.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid, err, mem_we, mem_io_sel;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_datain;
    logic [31:0] mem_dataout;

    always #5 clock = ~clock;

    dmem_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .a_req       (a_req),
        .a_we        (a_we),
        .a_addr      (a_addr),
        .a_wdata     (a_wdata),
        .b_req       (b_req),
        .b_we        (b_we),
        .b_addr      (b_addr),
        .b_wdata     (b_wdata),
        .a_gnt       (a_gnt),
        .b_gnt       (b_gnt),
        .a_rvalid    (a_rvalid),
        .b_rvalid    (b_rvalid),
        .a_rdata     (a_rdata),
        .b_rdata     (b_rdata),
        .err         (err),
        .mem_addr    (mem_addr),
        .mem_datain  (mem_datain),
        .mem_we      (mem_we),
        .mem_io_sel  (mem_io_sel),
        .mem_dataout (mem_dataout)
    );

    // Environment memory: 64 words, synchronous read, cleared by reset.
    logic [31:0] env_mem [64];
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= '0;
            mem_dataout <= '0;
        end else begin
            if (mem_we) env_mem[mem_addr[7:2]] <= mem_datain;
            mem_dataout <= env_mem[mem_addr[7:2]];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: contents of memory, who was served last, the last
    // granted command, and reads awaiting their one-cycle return.
    typedef struct {
        logic       is_b;
        logic [5:0] idx;
    } rd_t;

    logic [31:0] shadow [64];
    rd_t         pend_q [$];
    logic        last_b   = 1'b1;
    logic [31:0] held_addr = '0;
    logic [31:0] held_data = '0;

    task automatic step(input logic rst,
                        input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad,
                        input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd,
                        output logic ga, output logic gb);
        logic        granted, mis, w_we, ev_a, ev_b;
        logic [31:0] w_addr, w_data, ea_rd, eb_rd, e_maddr, e_mdata;
        rd_t         p;
        @(negedge clock);
        reset = rst;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #1;
        ga = 1'b0; gb = 1'b0; ev_a = 1'b0; ev_b = 1'b0; ea_rd = '0; eb_rd = '0;
        if (!rst && pend_q.size() > 0) begin
            p = pend_q.pop_front();
            if (p.is_b) begin ev_b = 1'b1; eb_rd = shadow[p.idx]; end
            else        begin ev_a = 1'b1; ea_rd = shadow[p.idx]; end
        end
        if (!rst) begin
            if (ar && br) begin ga = last_b; gb = !last_b; end
            else          begin ga = ar;     gb = br;      end
        end
        granted = ga | gb;
        w_we    = gb ? bw : aw;
        w_addr  = gb ? ba : aa;
        w_data  = gb ? bd : ad;
        mis     = (w_addr[1:0] != 2'b00);
        e_maddr = rst ? 32'd0 : (granted ? w_addr : held_addr);
        e_mdata = rst ? 32'd0 : (granted ? w_data : held_data);

        check_val("a_gnt",      a_gnt,      ga);
        check_val("b_gnt",      b_gnt,      gb);
        check_val("a_rvalid",   a_rvalid,   ev_a);
        check_val("b_rvalid",   b_rvalid,   ev_b);
        check_val("a_rdata",    a_rdata,    ea_rd);
        check_val("b_rdata",    b_rdata,    eb_rd);
        check_val("err",        err,        granted && mis);
        check_val("mem_we",     mem_we,     granted && w_we && !mis);
        check_val("mem_addr",   mem_addr,   e_maddr);
        check_val("mem_datain", mem_datain, e_mdata);
        check_val("mem_io_sel", mem_io_sel, e_maddr[7]);

        if (rst) begin
            pend_q.delete();
            for (int i = 0; i < 64; i++) shadow[i] = '0;
            last_b    = 1'b1;
            held_addr = '0;
            held_data = '0;
        end else if (granted) begin
            last_b    = gb;
            held_addr = w_addr;
            held_data = w_data;
            if (!mis) begin
                if (w_we) shadow[w_addr[7:2]] = w_data;
                else      pend_q.push_back('{gb, w_addr[7:2]});
            end
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] x;
        x = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        if ($urandom_range(0, 7) == 0) x[1:0] = 2'($urandom_range(1, 3));
        return x;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic        ga, gb;
        logic        ap, apw, bp, bpw, rs;
        logic [31:0] apa, apd, bpa, bpd;

        for (int i = 0; i < 64; i++) shadow[i] = '0;

        // Requests during reset are ignored.
        for (int i = 0; i < 3; i++)
            step(1, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, ga, gb);

        // Continuous tie: alternate starting with A.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, ga, gb);
            check_val("rr_alt_a", a_gnt, (i % 2) == 0);
            check_val("rr_alt_b", b_gnt, (i % 2) == 1);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);

        // A writes then reads 0x10.
        step(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, ga, gb);
        step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, ga, gb);
        check_val("rd10_gnt", a_gnt, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        check_val("rd10_data",   a_rdata,  32'hDEADBEEF);
        check_val("rd10_bvalid", b_rvalid, 1'b0);

        // IO-space and DRAM-space writes from B.
        step(0, 0, 0, 0, 0, 1, 1, 32'h80, 32'h3FF, ga, gb);
        check_val("io_sel_hi", mem_io_sel, 1'b1);
        check_val("io_we",     mem_we,     1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        check_val("io_we_drop", mem_we, 1'b0);
        step(0, 0, 0, 0, 0, 1, 1, 32'h08, 32'h55, ga, gb);
        check_val("io_sel_lo", mem_io_sel, 1'b0);

        // Back-to-back reads from A then B.
        step(0, 1, 1, 32'h04, 32'h11110004, 0, 0, 0, 0, ga, gb);
        step(0, 1, 0, 32'h04, 0, 0, 0, 0, 0, ga, gb);
        step(0, 0, 0, 0, 0, 1, 0, 32'h08, 0, ga, gb);
        check_val("pipe_a_valid", a_rvalid, 1'b1);
        check_val("pipe_a_data",  a_rdata,  32'h11110004);
        check_val("pipe_b_early", b_rvalid, 1'b0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        check_val("pipe_b_valid", b_rvalid, 1'b1);
        check_val("pipe_b_data",  b_rdata,  32'h55);
        check_val("pipe_a_late",  a_rvalid, 1'b0);

        // Misaligned write: granted, flagged, not written.
        step(0, 1, 1, 32'h06, 32'hBAD, 0, 0, 0, 0, ga, gb);
        check_val("mis_gnt", a_gnt,  1'b1);
        check_val("mis_err", err,    1'b1);
        check_val("mis_we",  mem_we, 1'b0);
        step(0, 1, 0, 32'h04, 0, 0, 0, 0, 0, ga, gb);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        check_val("mis_unchanged", a_rdata, 32'h11110004);

        // Reset right after a read grant drops the return.
        step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, ga, gb);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);
        check_val("rst_drop_rvalid", a_rvalid, 1'b0);
        step(0, 1, 0, 32'h20, 0, 1, 0, 32'h24, 0, ga, gb);
        check_val("rst_tie_a", a_gnt, 1'b1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gb);

        // Randomized traffic; requesters hold their command until granted.
        ap = 0; apw = 0; apa = 0; apd = 0;
        bp = 0; bpw = 0; bpa = 0; bpd = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!ap && $urandom_range(0, 9) < 6) begin
                ap = 1; apw = 1'($urandom_range(0, 1)); apa = rand_addr(); apd = $urandom;
            end
            if (!bp && $urandom_range(0, 9) < 6) begin
                bp = 1; bpw = 1'($urandom_range(0, 1)); bpa = rand_addr(); bpd = $urandom;
            end
            rs = ($urandom_range(0, 99) == 0);
            step(rs, ap, apw, apa, apd, bp, bpw, bpa, bpd, ga, gb);
            if (ga) ap = 0;
            if (gb) bp = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DW, 32, data width.
REQ-002 SHALL have parameter AW, 32, address width.
REQ-003 SHALL have parameter IO_BIT, 7, address bit selecting IO space (1) over DRAM (0).
REQ-004 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports a_req/b_req  input  1  requester A (CPU) / B (DMA) transaction request.
REQ-007 SHALL have ports a_we/b_we  input  1  write (1) or read (0).
REQ-008 SHALL have ports a_addr/b_addr  input  AW  byte address.
REQ-009 SHALL have ports a_wdata/b_wdata  input  DW  write data.
REQ-010 SHALL have ports a_gnt/b_gnt  output  1  request accepted this cycle.
REQ-011 SHALL have ports a_rvalid/b_rvalid  output  1  read data valid.
REQ-012 SHALL have ports a_rdata/b_rdata  output  DW  read data.
REQ-013 SHALL have port err  output  1  one-cycle pulse on misaligned access.
REQ-014 SHALL have ports mem_addr (AW), mem_datain (DW), mem_we (1), mem_io_sel (1)  output  memory-side command.
REQ-015 SHALL have port mem_dataout  input  DW  synchronous-read memory data, valid one cycle after address.

Function
REQ-016 Requesters SHALL hold req/we/addr/wdata stable until gnt; gnt is combinational from req and arbiter state.
REQ-017 At most one gnt SHALL be high per cycle; single requester is granted in the same cycle it requests.
REQ-018 Both requesting: grant the requester not granted most recently (round-robin); last-grant pointer updates only on a grant.
REQ-019 Granted cycle: mem_addr = owner addr, mem_datain = owner wdata, mem_io_sel = addr[IO_BIT], mem_we = owner we and aligned.
REQ-020 No grant: mem_we SHALL be 0; mem_addr/mem_datain hold last granted values.
REQ-021 FSM states IDLE, RD_A, RD_B: any granted read to A/B -> RD_A/RD_B; write, no grant, or misaligned access -> IDLE; evaluated every cycle.
REQ-022 In RD_A (RD_B), a_rvalid (b_rvalid) SHALL be 1 and a_rdata (b_rdata) = mem_dataout; read latency exactly 1 cycle after gnt.
REQ-023 A new grant SHALL be allowed in RD_A/RD_B cycles (fully pipelined, one transaction per cycle).
REQ-024 rdata SHALL be 0 when corresponding rvalid is 0.
REQ-025 Misaligned access (addr[1:0] != 0): gnt still issued, mem_we forced 0, err pulses in gnt cycle, no rvalid follows.
REQ-026 Writes complete in the gnt cycle; no acknowledge beyond gnt.

Reset
REQ-027 While reset is high: all gnt, rvalid, err, mem_we = 0; rdata = 0; mem_addr, mem_datain = 0; FSM = IDLE; pointer = "B last" (A wins first tie).
REQ-028 Reset asserted mid-read SHALL drop the pending rvalid; the read is lost and not replayed.
REQ-029 Requests during reset SHALL be ignored; first grant possible in the cycle after reset deasserts.

Structure
REQ-030 FSM state encoding, owner encoding (OWN_A, OWN_B) and alignment mask SHALL reside in shared package dmem_pkg.
REQ-031 Round-robin arbitration SHALL be one sub-module rr_arb2 (two req in, one-hot gnt out, pointer internal); datapath mux and FSM stay in dmem_arbiter.

Verification
REQ-032 A-only read addr 0x10 after memory written 0xDEADBEEF -> a_gnt same cycle, a_rvalid next cycle, a_rdata 0xDEADBEEF, b_* idle.
REQ-033 A and B request every cycle for 6 cycles -> grants alternate A,B,A,B,A,B starting with A after reset.
REQ-034 B write 0x0000_0080 data 0x3FF -> mem_io_sel=1, mem_we=1 for one cycle; write to 0x08 -> mem_io_sel=0.
REQ-035 A read 0x04 then B read 0x08 in consecutive cycles -> a_rvalid cycle N+1, b_rvalid cycle N+2, correct data each, no overlap.
REQ-036 A write addr 0x06 -> a_gnt=1, err=1, mem_we=0, memory unchanged.
REQ-037 Reset asserted the cycle after an A read grant -> a_rvalid stays 0; next tie after reset granted to A.
